// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV M-extension multiply/divide unit
// Define MUL_DIV_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle multiplier.
module mul_div_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            is_op_x_32,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            r_state;
  logic              r_in_ready, r_out_valid, r_busy;
  logic [XLEN-1:0]   r_result;
  logic [1:0]        r_op;
  logic              r_w, r_neg, r_rneg, r_byp;
  logic [6:0]        r_cnt;
  logic [2*XLEN-1:0] r_acc, r_mc;
  logic [XLEN-1:0]   r_mp, r_rem, r_quo, r_dv;

  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic sgn);
    logic [XLEN-1:0] r;
    r = (sgn && v[31]) ? '1 : '0;
    r[31:0] = v[31:0];
    return r;
  endfunction

  logic            w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_dz, w_ovf;
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min, w_byp_sel, w_byp_res;

  always_comb begin
    w_a_sgn = 1'b0;
    w_b_sgn = 1'b0;
    if (!op[2]) begin
      w_a_sgn = is_op_x_32 || (op != 3'b011);
      w_b_sgn = is_op_x_32 || !op[1];
    end else begin
      w_a_sgn = !op[0];
      w_b_sgn = !op[0];
    end
  end

  assign w_a_ext = is_op_x_32 ? ext32(a, w_a_sgn) : a;
  assign w_b_ext = is_op_x_32 ? ext32(b, w_b_sgn) : b;
  assign w_a_neg = w_a_sgn & w_a_ext[XLEN-1];
  assign w_b_neg = w_b_sgn & w_b_ext[XLEN-1];
  assign w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
  assign w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;

  // Divide corner cases resolve at accept time and skip the iteration entirely.
  assign w_min     = is_op_x_32 ? ~(XLEN'(32'h7fff_ffff)) : (XLEN'(1) << (XLEN-1));
  assign w_dz      = (w_b_ext == '0);
  assign w_ovf     = op[2] & w_a_sgn & (w_a_ext == w_min) & (w_b_ext == '1);
  assign w_byp_sel = w_dz ? (op[1] ? w_a_ext : '1) : (op[1] ? '0 : w_a_ext);
  assign w_byp_res = is_op_x_32 ? ext32(w_byp_sel, 1'b1) : w_byp_sel;

  logic [2*XLEN-1:0] w_acc_nx, w_prod;
  logic              w_mul_last, w_div_last;
  logic [XLEN-1:0]   w_mul_res;

  assign w_div_last = (r_cnt == (r_w ? 7'd31 : 7'(XLEN-1)));
`ifdef MUL_DIV_FAST_MUL_EN
  assign w_acc_nx   = r_acc + r_mc * {{XLEN{1'b0}}, r_mp};
  assign w_mul_last = 1'b1;
`else
  assign w_acc_nx   = r_acc + (r_mp[0] ? r_mc : '0);
  assign w_mul_last = w_div_last;
`endif
  assign w_prod    = r_neg ? -w_acc_nx : w_acc_nx;
  assign w_mul_res = r_w ? ext32(w_prod[XLEN-1:0], 1'b1)
                   : (r_op == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // Restoring step: shift one dividend bit into the partial remainder, subtract if it fits.
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_sub, w_rem_nx, w_quo_nx, w_q, w_r, w_div_sel, w_div_res;

  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_ge      = (w_shift >= {1'b0, r_dv});
  assign w_sub     = w_shift[XLEN-1:0] - r_dv;
  assign w_rem_nx  = w_ge ? w_sub : w_shift[XLEN-1:0];
  assign w_quo_nx  = {r_quo[XLEN-2:0], w_ge};
  assign w_q       = r_neg ? -w_quo_nx : w_quo_nx;
  assign w_r       = r_rneg ? -w_rem_nx : w_rem_nx;
  assign w_div_sel = r_op[1] ? w_r : w_q;
  assign w_div_res = r_w ? ext32(w_div_sel, 1'b1) : w_div_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_op        <= '0;
      r_w         <= 1'b0;
      r_neg       <= 1'b0;
      r_rneg      <= 1'b0;
      r_byp       <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mc        <= '0;
      r_mp        <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dv        <= '0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_state    <= op[2] ? DIV : MUL;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b1;
          r_op       <= op[1:0];
          r_w        <= is_op_x_32;
          r_neg      <= w_a_neg ^ w_b_neg;
          r_rneg     <= w_a_neg;
          r_byp      <= op[2] & (w_dz | w_ovf);
          r_cnt      <= '0;
          r_acc      <= '0;
          r_mc       <= {{XLEN{1'b0}}, w_a_mag};
          r_mp       <= w_b_mag;
          r_rem      <= '0;
          r_quo      <= is_op_x_32 ? (w_a_mag << (XLEN-32)) : w_a_mag;
          r_dv       <= w_b_mag;
          if (op[2] & (w_dz | w_ovf)) r_result <= w_byp_res;
        end
        MUL: begin
          r_acc <= w_acc_nx;
          r_mc  <= r_mc << 1;
          r_mp  <= r_mp >> 1;
          r_cnt <= r_cnt + 7'd1;
          if (w_mul_last) begin
            r_result    <= w_mul_res;
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DIV: begin
          if (r_byp) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + 7'd1;
            if (w_div_last) begin
              r_result    <= w_div_res;
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        DONE: if (out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign result    = r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit (XLEN=64)
module tb_mul_div_unit;
  localparam int XLEN = 64;
`ifdef MUL_DIV_FAST_MUL_EN
  localparam int ML64 = 2;
  localparam int ML32 = 2;
`else
  localparam int ML64 = 65;
  localparam int ML32 = 33;
`endif
  localparam int DL64 = 65;
  localparam int DL32 = 33;
  localparam int BYP  = 2;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic            clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready;
  logic [2:0]      op = '0;
  logic            is_op_x_32 = 1'b0, flush = 1'b0, out_valid, out_ready = 1'b1, busy;
  logic [XLEN-1:0] a = '0, b = '0, result;

  mul_div_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .is_op_x_32(is_op_x_32), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [63:0] res; int due; } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  logic seen = 1'b0;
  int   first = 0;
  exp_t e;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        first = cyc;
      end
      if (out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output actual=%h required=none", result);
        end else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("latency", 64'(first), 64'(e.due));
        end
        seen = 1'b0;
      end
    end else begin
      seen = 1'b0;
    end
  end

  task automatic drive(input logic [2:0] o, input logic w, input logic [63:0] aa, input logic [63:0] bb,
                       input logic push, input logic [63:0] er, input int lat);
    @(negedge clk);
    if (push) check("in_ready_idle", 64'(in_ready), 64'd1);
    op = o; is_op_x_32 = w; a = aa; b = bb; in_valid = 1'b1;
    if (push) sb.push_back('{er, cyc + lat});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 300; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout actual=pending required=done");
      sb.delete();
    end
  endtask

  task automatic run(input logic [2:0] o, input logic w, input logic [63:0] aa, input logic [63:0] bb,
                     input logic [63:0] er, input int lat);
    drive(o, w, aa, bb, 1'b1, er, lat);
    wait_done();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", result, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    run(3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, ML64);
    run(3'b011, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, ML64);
    run(3'b001, 1'b0, ONES, ONES, 64'd0, ML64);
    run(3'b010, 1'b0, ONES, ONES, ONES, ML64);
    run(3'b000, 1'b0, 64'h1234_5678, 64'h10, 64'h1_2345_6780, ML64);
    run(3'b001, 1'b1, 64'h0000_0001_0000_0003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000, ML32);
    run(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, DL64);
    run(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, DL64);
    run(3'b101, 1'b0, 64'd5, 64'd0, ONES, BYP);
    run(3'b111, 1'b0, 64'd5, 64'd0, 64'd5, BYP);
    run(3'b100, 1'b1, 64'h0000_0000_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, BYP);
    run(3'b110, 1'b1, 64'h0000_0000_8000_0000, ONES, 64'd0, BYP);
    run(3'b100, 1'b0, 64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, BYP);
    run(3'b110, 1'b0, 64'h8000_0000_0000_0000, ONES, 64'd0, BYP);
    run(3'b101, 1'b0, 64'd100, 64'd7, 64'd14, DL64);
    run(3'b111, 1'b0, 64'd100, 64'd7, 64'd2, DL64);
    run(3'b101, 1'b0, ONES, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, DL64);
    run(3'b101, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'd7, 64'd14, DL32);
    run(3'b110, 1'b1, 64'h0000_0000_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, DL32);
    run(3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, ONES, DL32);
    run(3'b111, 1'b1, 64'h0000_0000_8000_0005, 64'h10, 64'd5, DL32);
    run(3'b100, 1'b1, 64'd7, 64'h1_0000_0000, ONES, BYP);
    run(3'b111, 1'b1, 64'h0000_0000_8000_0001, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0001, BYP);

    // Consumer stall in DONE, with a stray request that must be ignored
    out_ready = 1'b0;
    drive(3'b011, 1'b0, ONES, ONES, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, ML64);
    for (int k = 0; k < 100; k++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    op = 3'b000; a = 64'd1; b = 64'd1; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_done();
    @(negedge clk);
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_out_valid", 64'(out_valid), 64'd0);

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    op = 3'b000; a = 64'd3; b = 64'd3; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle_flush_busy", 64'(busy), 64'd0);
    check("idle_flush_in_ready", 64'(in_ready), 64'd1);

    // Flush mid-divide
    drive(3'b100, 1'b0, 64'd1000, 64'd3, 1'b0, 64'd0, 0);
    repeat (19) @(negedge clk);
    check("div_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);

    // Reset mid-multiply
    drive(3'b000, 1'b0, 64'd9, 64'd9, 1'b0, 64'd0, 0);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_out_valid", 64'(out_valid), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_in_ready", 64'(in_ready), 64'd1);
    repeat (80) @(negedge clk);
    check("quiet_out_valid", 64'(out_valid), 64'd0);

    run(3'b000, 1'b0, 64'd6, 64'd7, 64'd42, ML64);
    run(3'b101, 1'b1, 64'h0000_0000_8000_0005, 64'h10, 64'h0800_0000, DL32);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width in bits (legal values 32 and 64).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port op  input  3  RV M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port is_op_x_32  input  1  word (*W) variant.
REQ-008 SHALL have ports a, b  input  XLEN  operands rs1, rs2.
REQ-009 SHALL have port flush  input  1  abort current operation.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port result  output  XLEN  computed value.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, DONE; in_ready = 1 only in IDLE.
REQ-015 SHALL accept a request on in_valid & in_ready, latching op, is_op_x_32 and operands; IDLE -> MUL (op[2]=0) or DIV (op[2]=1).
REQ-016 SHALL iterate one bit per cycle for N cycles, N = 32 when is_op_x_32 else XLEN; MUL/DIV -> DONE after cycle N, giving out_valid N+1 cycles after acceptance.
REQ-017 SHALL compute multiply as radix-2 shift-add on magnitudes with sign correction per op; MUL returns low XLEN bits, MULH/MULHSU/MULHU high XLEN bits of the 2*XLEN product.
REQ-018 SHALL compute divide as restoring division on magnitudes; quotient sign = sign(a) XOR sign(b), remainder sign = sign(a), signed ops only.
REQ-019 SHALL, when is_op_x_32, use a[31:0], b[31:0] (sign- or zero-extended per op) and return the 32-bit result sign-extended from bit 31; op 001-011 with is_op_x_32 SHALL be treated as MULW.
REQ-020 SHALL, on divide by zero, bypass iteration and enter DONE the next cycle: DIV/DIVU quotient all ones, REM/REMU = dividend.
REQ-021 SHALL, on signed overflow (most-negative / -1, 32- or XLEN-bit as applicable), bypass iteration: quotient = dividend, remainder = 0.
REQ-022 SHALL, in DONE, hold out_valid = 1 and result stable until out_ready = 1, then return to IDLE next cycle.
REQ-023 SHALL, on flush = 1 in any state, go to IDLE next cycle with out_valid = 0 and no result delivered; flush in IDLE with in_valid SHALL block acceptance.
REQ-024 SHALL ignore in_valid outside IDLE (no queueing; single outstanding operation).

Reset
REQ-025 SHALL, while rst_n = 0, immediately force state IDLE, out_valid = 0, busy = 0, result = 0, in_ready = 1 after release; reset mid-operation discards the operation.

Configuration
REQ-026 SHALL, with macro MUL_DIV_FAST_MUL_EN defined, compute all multiplies with a single-cycle combinational multiplier (MUL state lasts 1 cycle, out_valid 2 cycles after acceptance); without it, use the iterative multiplier of REQ-016/017. Divide behaviour is identical in both builds.

Verification
REQ-027 MUL, XLEN=64, a=-3, b=7, out_ready=1 -> out_valid 65 cycles after accept (2 with MUL_DIV_FAST_MUL_EN), result=0xFFFF_FFFF_FFFF_FFEB.
REQ-028 MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> result 0xFFFF_FFFF_FFFF_FFFE; MULH same operands -> 0.
REQ-029 DIV a=-7, b=2 -> -3; REM -> -1; DIVU a=5, b=0 -> all ones in 2 cycles; REMU -> 5.
REQ-030 DIVW a=0x0000_0000_8000_0000, b=-1 -> result 0xFFFF_FFFF_8000_0000; REMW -> 0; no iteration.
REQ-031 out_ready held 0 for 10 cycles in DONE -> result and out_valid stable, in_ready=0; release -> IDLE next cycle.
REQ-032 flush at iteration 20 of DIV, then rst_n pulse mid-MUL -> out_valid never asserted for either, IDLE with in_ready=1; next request completes correctly.
